// File: rtl/latch_ctrl_pkg.sv
// Shared types and sizing helpers for the latch bank write controller.
// Holds the controller state encoding and the phase counter width math.
package latch_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ENABLE,
    HOLD,
    DONE
  } lwc_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  function automatic int cnt_w(input int s, input int e, input int h);
    return $clog2(max3(s, e, h) + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter; search starts at ptr.
// Produces a one-hot grant, its index and an any-request flag.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      idx,
  output logic               any
);

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!any && req[i] &&
            i == (int'(ptr) + k) % NUM_REQ) begin
          any    = 1'b1;
          gnt[i] = 1'b1;
          idx    = IW'(i);
        end
      end
    end
  end

endmodule

// File: rtl/latch_bank_write_ctrl.sv
// Arbitrated write sequencer for a bank of level-sensitive latches.
// Each write runs SETUP -> ENABLE -> HOLD -> DONE around a stable bus.
module latch_bank_write_ctrl
  import latch_ctrl_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int NUM_ENT   = 8,
  parameter int DATA_W    = 8,
  parameter int SETUP_CYC = 1,
  parameter int EN_CYC    = 2,
  parameter int HOLD_CYC  = 1,
  localparam int AW = $clog2(NUM_ENT),
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*AW-1:0]     req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]         lat_d,
  output logic [NUM_ENT-1:0]        lat_en,
  output logic                      busy,
  output logic                      done,
  output logic [IW-1:0]             done_id,
  output logic                      err
);

  localparam int CW = cnt_w(SETUP_CYC, EN_CYC, HOLD_CYC);

  lwc_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] id_q, id_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_d;

  logic [NUM_REQ-1:0] gnt;
  logic [IW-1:0]      gnt_idx;
  logic               any;
  logic               hs;
  logic               last;

  logic [AW-1:0]     addr_sel;
  logic [DATA_W-1:0] data_sel;

  logic [NUM_ENT-1:0] en_d;
  logic               busy_d;
  logic               done_d;
  logic [IW-1:0]      done_id_d;
  logic               err_d;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_arb (
    .req(req_valid),
    .ptr(ptr_q),
    .gnt(gnt),
    .idx(gnt_idx),
    .any(any)
  );

  assign req_ready =
    (state_q == IDLE && !reset) ? gnt : '0;
  assign hs   = any && state_q == IDLE && !reset;
  assign last = (cnt_q == '0);

  always_comb begin
    addr_sel = '0;
    data_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        addr_sel = req_addr[i*AW +: AW];
        data_sel = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    addr_d  = addr_q;
    data_d  = lat_d;
    unique case (state_q)
      IDLE: begin
        if (hs) begin
          state_d = SETUP;
          cnt_d   = CW'(SETUP_CYC - 1);
          addr_d  = addr_sel;
          data_d  = data_sel;
          id_d    = gnt_idx;
          ptr_d   = (gnt_idx == IW'(NUM_REQ - 1)) ?
                    '0 : gnt_idx + IW'(1);
        end
      end
      SETUP: begin
        if (last) begin
          state_d = ENABLE;
          cnt_d   = CW'(EN_CYC - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ENABLE: begin
        if (last) begin
          state_d = HOLD;
          cnt_d   = CW'(HOLD_CYC - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      HOLD: begin
        if (last) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Out-of-range addresses match no enable bit, so timing is unaffected.
  always_comb begin
    en_d = '0;
    for (int i = 0; i < NUM_ENT; i++) begin
      en_d[i] = (state_d == ENABLE) &&
                (int'(addr_d) == i);
    end
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
    done_id_d = done_d ? id_d : '0;
    err_d     = done_d && (int'(addr_d) >= NUM_ENT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      id_q    <= '0;
      addr_q  <= '0;
      lat_d   <= '0;
      lat_en  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      done_id <= '0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      lat_d   <= data_d;
      lat_en  <= en_d;
      busy    <= busy_d;
      done    <= done_d;
      done_id <= done_id_d;
      err     <= err_d;
    end
  end

endmodule

// File: tb/tb_latch_bank_write_ctrl.sv
// Directed bench for latch_bank_write_ctrl across three configurations.
// Instance 0 default, 1 with NUM_ENT=6, 2 with SETUP/EN/HOLD = 3/1/2.
module tb_latch_bank_write_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic [1:0]  rv;
  logic [5:0]  ra;
  logic [15:0] rd;
  int sel;
  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  logic [1:0] rv_g [3];
  logic [1:0] rdy  [3];
  logic [7:0] ld   [3];
  logic [7:0] en   [3];
  logic       bsy  [3];
  logic       dn   [3];
  logic       did  [3];
  logic       er   [3];
  logic [5:0] en_b;

  always #5 clk = ~clk;

  assign rv_g[0] = (sel == 0) ? rv : 2'b00;
  assign rv_g[1] = (sel == 1) ? rv : 2'b00;
  assign rv_g[2] = (sel == 2) ? rv : 2'b00;
  assign en[1]   = {2'b00, en_b};

  latch_bank_write_ctrl u_a (
    .clk(clk), .reset(reset),
    .req_valid(rv_g[0]), .req_addr(ra), .req_data(rd),
    .req_ready(rdy[0]), .lat_d(ld[0]), .lat_en(en[0]),
    .busy(bsy[0]), .done(dn[0]), .done_id(did[0]), .err(er[0])
  );

  latch_bank_write_ctrl #(.NUM_ENT(6)) u_b (
    .clk(clk), .reset(reset),
    .req_valid(rv_g[1]), .req_addr(ra), .req_data(rd),
    .req_ready(rdy[1]), .lat_d(ld[1]), .lat_en(en_b),
    .busy(bsy[1]), .done(dn[1]), .done_id(did[1]), .err(er[1])
  );

  latch_bank_write_ctrl #(
    .SETUP_CYC(3), .EN_CYC(1), .HOLD_CYC(2)
  ) u_c (
    .clk(clk), .reset(reset),
    .req_valid(rv_g[2]), .req_addr(ra), .req_data(rd),
    .req_ready(rdy[2]), .lat_d(ld[2]), .lat_en(en[2]),
    .busy(bsy[2]), .done(dn[2]), .done_id(did[2]), .err(er[2])
  );

  logic [7:0] pld [3];
  logic [7:0] pen [3];
  logic       prst;

  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if ($countones(en[i]) > 1) begin
          errors++;
          $display("FAIL onehot inst%0d: lat_en=%b", i, en[i]);
        end
        checks++;
        if (!prst && ld[i] !== pld[i] &&
            (en[i] != 0 || pen[i] != 0)) begin
          errors++;
          $display("FAIL dstable inst%0d: lat_d %h->%h en %b->%b",
                   i, pld[i], ld[i], pen[i], en[i]);
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      pld[i] = ld[i];
      pen[i] = en[i];
    end
    prst = reset;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    sel = 0;
    rv = 2'b01;
    ra = 6'd3;
    rd = 16'h00A5;
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rdy[i] !== 2'b00) begin
        errors++;
        $display("FAIL rst_ready inst%0d: got %b want 00", i, rdy[i]);
      end
      checks++;
      if (ld[i] !== 8'h00 || en[i] !== 8'h00) begin
        errors++;
        $display("FAIL rst_bus inst%0d: lat_d=%h lat_en=%b want 0",
                 i, ld[i], en[i]);
      end
      checks++;
      if ({bsy[i], dn[i], did[i], er[i]} !== 4'b0000) begin
        errors++;
        $display("FAIL rst_flags inst%0d: busy/done/id/err=%b want 0000",
                 i, {bsy[i], dn[i], did[i], er[i]});
      end
    end
    reset = 1'b0;
    rv = 2'b00;
    tick();
    chk_on = 1'b1;
  endtask

  task automatic test_single();
    logic [7:0] xen;
    sel = 0;
    ra = {3'd0, 3'd3};
    rd = 16'h00A5;
    rv = 2'b01;
    #1;
    checks++;
    if (rdy[0] !== 2'b01) begin
      errors++;
      $display("FAIL single_ready: got %b want 01", rdy[0]);
    end
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 1) rv = 2'b00;
      xen = (k == 2 || k == 3) ? 8'h08 : 8'h00;
      checks++;
      if (ld[0] !== 8'hA5 || en[0] !== xen) begin
        errors++;
        $display("FAIL single_bus k=%0d: lat_d=%h lat_en=%b want A5 %b",
                 k, ld[0], en[0], xen);
      end
      checks++;
      if (dn[0] !== (k == 5) || bsy[0] !== (k <= 5)) begin
        errors++;
        $display("FAIL single_ctl k=%0d: done=%b busy=%b want %b %b",
                 k, dn[0], bsy[0], k == 5, k <= 5);
      end
      if (k == 5) begin
        checks++;
        if (did[0] !== 1'b0 || er[0] !== 1'b0) begin
          errors++;
          $display("FAIL single_id: done_id=%b err=%b want 0 0",
                   did[0], er[0]);
        end
      end
    end
  endtask

  task automatic test_contention();
    logic [1:0] xr;
    bit odd;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sel = 0;
    ra = {3'd6, 3'd1};
    rd = 16'h6611;
    rv = 2'b11;
    #1;
    for (int c = 0; c < 24; c++) begin
      odd = ((c / 6) % 2) == 1;
      xr = (c % 6 == 0) ? (odd ? 2'b10 : 2'b01) : 2'b00;
      checks++;
      if (rdy[0] !== xr) begin
        errors++;
        $display("FAIL cont_ready c=%0d: got %b want %b", c, rdy[0], xr);
      end
      if (c % 6 == 1) begin
        checks++;
        if (ld[0] !== (odd ? 8'h66 : 8'h11)) begin
          errors++;
          $display("FAIL cont_data c=%0d: got %h", c, ld[0]);
        end
      end
      if (c % 6 == 2) begin
        checks++;
        if (en[0] !== (odd ? 8'h40 : 8'h02)) begin
          errors++;
          $display("FAIL cont_en c=%0d: got %b", c, en[0]);
        end
      end
      if (c % 6 == 5) begin
        checks++;
        if (dn[0] !== 1'b1 || did[0] !== odd) begin
          errors++;
          $display("FAIL cont_done c=%0d: done=%b id=%b want 1 %b",
                   c, dn[0], did[0], odd);
        end
      end
      tick();
    end
    rv = 2'b00;
    tick();
  endtask

  task automatic test_out_of_range();
    sel = 1;
    ra = {3'd0, 3'd7};
    rd = 16'h003C;
    rv = 2'b01;
    #1;
    checks++;
    if (rdy[1] !== 2'b01) begin
      errors++;
      $display("FAIL oor_ready: got %b want 01", rdy[1]);
    end
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 1) rv = 2'b00;
      checks++;
      if (en[1] !== 8'h00 || ld[1] !== 8'h3C) begin
        errors++;
        $display("FAIL oor_bus k=%0d: lat_en=%b lat_d=%h want 0 3C",
                 k, en[1], ld[1]);
      end
      checks++;
      if (dn[1] !== (k == 5) || er[1] !== (k == 5) ||
          bsy[1] !== (k <= 5)) begin
        errors++;
        $display("FAIL oor_ctl k=%0d: done=%b err=%b busy=%b",
                 k, dn[1], er[1], bsy[1]);
      end
    end
  endtask

  task automatic test_reset_mid();
    sel = 0;
    ra = {3'd0, 3'd2};
    rd = 16'h775A;
    rv = 2'b01;
    #1;
    tick();
    rv = 2'b00;
    tick();
    checks++;
    if (en[0] !== 8'h04) begin
      errors++;
      $display("FAIL mid_pre: lat_en=%b want 00000100", en[0]);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (en[0] !== 8'h00 || ld[0] !== 8'h00 ||
        bsy[0] !== 1'b0 || dn[0] !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst: en=%b d=%h busy=%b done=%b want 0",
               en[0], ld[0], bsy[0], dn[0]);
    end
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++;
      if (dn[0] !== 1'b0 || bsy[0] !== 1'b0) begin
        errors++;
        $display("FAIL mid_quiet k=%0d: done=%b busy=%b want 0 0",
                 k, dn[0], bsy[0]);
      end
    end
    ra = {3'd5, 3'd4};
    rv = 2'b11;
    #1;
    checks++;
    if (rdy[0] !== 2'b01) begin
      errors++;
      $display("FAIL mid_regrant: got %b want 01", rdy[0]);
    end
    tick();
    rv = 2'b00;
    checks++;
    if (ld[0] !== 8'h5A) begin
      errors++;
      $display("FAIL mid_data: got %h want 5A", ld[0]);
    end
    for (int k = 0; k < 6; k++) tick();
  endtask

  task automatic test_sweep();
    logic [7:0] xen;
    sel = 2;
    ra = {3'd0, 3'd5};
    rd = 16'h00C3;
    rv = 2'b01;
    #1;
    checks++;
    if (rdy[2] !== 2'b01) begin
      errors++;
      $display("FAIL sweep_ready: got %b want 01", rdy[2]);
    end
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k == 1) rv = 2'b00;
      xen = (k == 4) ? 8'h20 : 8'h00;
      checks++;
      if (en[2] !== xen || ld[2] !== 8'hC3) begin
        errors++;
        $display("FAIL sweep_bus k=%0d: lat_en=%b lat_d=%h want %b C3",
                 k, en[2], ld[2], xen);
      end
      checks++;
      if (dn[2] !== (k == 7) || bsy[2] !== (k <= 7)) begin
        errors++;
        $display("FAIL sweep_ctl k=%0d: done=%b busy=%b want %b %b",
                 k, dn[2], bsy[2], k == 7, k <= 7);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_out_of_range();
    test_reset_mid();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
